spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- Receiving end of the SPI link whose master side generates sclk from the PCLK baud divisor.
- Runs entirely on PCLK; sclk, mosi and ss_n are treated as asynchronous inputs, synchronised, and edge-detected.
- Deserialises mosi into rx words and serialises tx words onto miso for all four CPOL/CPHA modes, MSB- or LSB-first.
- Exchanges words with the local bus over valid/ready handshakes.

Parameters:
- DATA_W, 8: word length in bits (4..16).
- SYNC_STAGES, 2: flops in each input synchroniser (2 or 3).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  synchronous, active-high reset.
- spi_en  in  1  core enable; 0 forces IDLE.
- cpol  in  1  clock polarity.
- cpha  in  1  clock phase.
- lsbfe  in  1  1 = LSB first.
- sclk  in  1  serial clock from master (async).
- ss_n  in  1  slave select, active low (async).
- mosi  in  1  serial data in (async).
- miso  out  1  serial data out.
- miso_oe  out  1  miso output enable.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx holding buffer empty.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  rx_data valid, held until accepted.
- rx_ready  in  1  consumer accepts rx_data.
- overrun  out  1  sticky: word completed while rx_valid high.
- underrun  out  1  sticky: word started with tx buffer empty.
- err_clr  in  1  clears overrun and underrun.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, underrun=0.
  - Synchronisers preset to idle levels: sclk=cpol, ss_n=1, mosi=0.
- Input synchronisers: sclk, ss_n and mosi each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with one extra flop.
- Edge qualification:
  - lead = rising edge if cpol=0, falling edge if cpol=1; trail is the opposite edge.
  - cpha=0: sample on lead, shift on trail. cpha=1: shift on lead, sample on trail.
- Timing constraint: sclk half-period must be at least SYNC_STAGES+2 PCLK cycles. Faster sclk is out of scope.
- Pin-to-sample latency: SYNC_STAGES+1 PCLK cycles after the pin edge.
- Configuration: cpol, cpha and lsbfe are registered in IDLE only and are held constant for the whole frame.
- FSM IDLE:
  - Moves to ACTIVE on the synchronised ss_n falling edge when spi_en=1.
  - On entry: bit_cnt=0; tx shift register loads from the tx buffer (or all-ones if the buffer is empty, with underrun set); buffer is freed so tx_ready=1 on the next cycle.
  - cpha=0: the first bit is driven on miso on the entry cycle.
  - cpha=1: the first bit is driven at the first shift edge.
- FSM ACTIVE:
  - miso_oe=1.
  - Sample edge: mosi_sync shifts into rx_shift (into the MSB side if lsbfe=1, LSB side otherwise); bit_cnt increments.
  - On the sample edge with bit_cnt=DATA_W-1, the word is complete:
    - If rx_valid=0: rx_data is loaded and rx_valid=1 the next cycle.
    - If rx_valid=1: the new word is dropped, rx_data is unchanged, and overrun is set.
    - bit_cnt wraps to 0.
  - Shift edge: the tx shift register advances and miso is updated.
  - At a word boundary (bit_cnt=0 after a wrap) the tx shift register reloads from the buffer with the same underrun rule as IDLE entry. This gives back-to-back words in a single ss_n frame.
  - cpha=0: the reload for the next word happens on the trail edge that ends the current word.
- ACTIVE exit to IDLE: synchronised ss_n rises, or spi_en=0.
  - miso_oe=0 the same cycle.
  - A partial word (bit_cnt≠0) is discarded with no rx_valid.
  - The tx buffer is untouched if it was not yet consumed.
- tx handshake: tx_ready=1 when the holding buffer is empty; a transfer occurs when tx_valid & tx_ready. Buffer load and core consume in the same cycle: consume wins first, so the newly offered word is accepted only if the buffer becomes empty.
- rx handshake: rx_valid & rx_ready clears rx_valid. If a new word completes in that same cycle, it is loaded and rx_valid stays 1 with no overrun.
- Sticky flags: cleared by err_clr. If err_clr and a set event occur in the same cycle, set wins.
- miso=0 when miso_oe=0.

Decomposition:
- Shared package spi_pkg: mode encoding constants (MODE0..MODE3 as {cpol,cpha}) and an FSM state typedef (IDLE, ACTIVE), shared with the master side.
- One natural sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall pulse outputs, instantiated for sclk and ss_n (mosi uses the synchroniser only).

Test Plan:
- Mode 0, lsbfe=0, tx_data=0xA5 preloaded; master sends 0x3C with 8 PCLK per half-period → rx_data=0x3C with a single rx_valid; master captures 0xA5 on miso.
- Modes 1, 2 and 3 each exchange 0x81 ↔ 0x7E, and lsbfe=1 in mode 0 with 0x01 → rx_data=0x01 with bit order reversed on the wire; miso_oe high only while ss_n low.
- Two back-to-back words 0x11, 0x22 in one frame with rx_ready=0 → rx_data=0x11, overrun=1; err_clr→overrun=0.
- Frame started with no tx_valid → miso shifts 0xFF, underrun=1; tx written mid-word is used for the next word.
- ss_n raised after 5 bits → no rx_valid, next frame receives a full correct word (bit_cnt restarted).
- PRESET asserted mid-word → all outputs at reset values the next cycle, tx_ready=1, subsequent frame correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings ({cpol,cpha}) and the frame FSM state type.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with rise/fall pulses taken from the last stage vs. one extra flop.
// Latency: q_o follows d_i after STAGES cycles; edge pulses coincide with the q_o change.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{rst_val_i}};
      prev_q <= rst_val_i;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave on PCLK: all four modes, MSB/LSB first, one-word tx holding buffer, rx word held until accepted.
// Pin-to-sample latency SYNC_STAGES+1 PCLK; a completed word with rx_valid still high is dropped (overrun).
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spi_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              underrun,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state_q;
  logic              cpol_q, cpha_q, lsbfe_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              wrap_q, first_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
  logic [DATA_W-1:0] txbuf_q;
  logic              txfull_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, overrun_q, underrun_q;
  logic              miso_q, miso_oe_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i(PCLK), .rst_i(PRESET), .rst_val_i(cpol), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk_i(PCLK), .rst_i(PRESET), .rst_val_i(1'b1), .d_i(ss_n),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Lead is the edge leaving the idle level; trail returns to it.
  logic any_edge_c, lead_c, trail_c;
  assign any_edge_c = sclk_rise | sclk_fall;
  assign lead_c     = any_edge_c & (sclk_s != cpol_q);
  assign trail_c    = any_edge_c & (sclk_s == cpol_q);

  logic active_c, entry_c, exit_c, run_c, sample_c, shift_c, word_done_c;
  logic tx_load_c, rx_take_c, ovr_set_c, und_set_c;
  logic [DATA_W-1:0] load_word_d, rx_word_d, tx_shift_d;

  assign active_c    = (state_q == ACTIVE);
  assign entry_c     = !active_c && spi_en && ss_fall;
  assign exit_c      = active_c && (!spi_en || ss_rise);
  assign run_c       = active_c && !exit_c && !ss_s;
  assign sample_c    = run_c && (cpha_q ? trail_c : lead_c);
  assign shift_c     = run_c && (cpha_q ? lead_c : trail_c);
  assign word_done_c = sample_c && (bit_cnt_q == LAST_BIT);

  assign tx_load_c   = entry_c || (shift_c && wrap_q);
  assign load_word_d = txfull_q ? txbuf_q : '1;
  assign tx_shift_d  = lsbfe_q ? {1'b0, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b0};
  assign rx_word_d   = lsbfe_q ? {mosi_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_s};

  // A word completing in the same cycle the consumer drains rx_data is taken, not dropped.
  assign rx_take_c   = word_done_c && (!rx_valid_q || rx_ready);
  assign ovr_set_c   = word_done_c && !rx_take_c;
  assign und_set_c   = tx_load_c && !txfull_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbfe_q    <= 1'b0;
      bit_cnt_q  <= '0;
      wrap_q     <= 1'b0;
      first_q    <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      txbuf_q    <= '0;
      txfull_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      // Consume happens first; an offer is only seen while the buffer was already empty.
      if (tx_valid && !txfull_q) begin
        txbuf_q  <= tx_data;
        txfull_q <= 1'b1;
      end else if (tx_load_c) begin
        txfull_q <= 1'b0;
      end

      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (rx_take_c) begin
        rx_data_q  <= rx_word_d;
        rx_valid_q <= 1'b1;
      end

      overrun_q  <= (overrun_q && !err_clr) || ovr_set_c;
      underrun_q <= (underrun_q && !err_clr) || und_set_c;

      case (state_q)
        IDLE: begin
          cpol_q    <= cpol;
          cpha_q    <= cpha;
          lsbfe_q   <= lsbfe;
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          if (entry_c) begin
            state_q   <= ACTIVE;
            miso_oe_q <= 1'b1;
            bit_cnt_q <= '0;
            wrap_q    <= 1'b0;
            first_q   <= cpha;
            tx_sh_q   <= load_word_d;
            miso_q    <= cpha ? 1'b0 : out_bit(load_word_d, lsbfe);
          end
        end
        ACTIVE: begin
          if (exit_c) begin
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            if (sample_c) begin
              rx_sh_q <= rx_word_d;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                wrap_q    <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (shift_c) begin
              if (wrap_q) begin
                tx_sh_q <= load_word_d;
                miso_q  <= out_bit(load_word_d, lsbfe_q);
                wrap_q  <= 1'b0;
              end else if (first_q) begin
                miso_q  <= out_bit(tx_sh_q, lsbfe_q);
                first_q <= 1'b0;
              end else begin
                tx_sh_q <= tx_shift_d;
                miso_q  <= out_bit(tx_shift_d, lsbfe_q);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = miso_q & miso_oe_q;
  assign miso_oe  = miso_oe_q;
  assign tx_ready = !txfull_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: behavioural SPI master plus rx/miso scoreboards.
module tb_spi_slave_core;

  localparam int HP = 8;

  logic       PCLK = 1'b0;
  logic       PRESET, spi_en, cpol, cpha, lsbfe, sclk, ss_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       overrun, underrun, err_clr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] mi;

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .spi_en(spi_en), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .underrun(underrun), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && rx_valid && rx_ready) begin
      if (rx_q.size() == 0) check("rx_spurious", 1, 0);
      else check("rx_data", rx_data, rx_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic tx_push(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge PCLK);
      if (tx_ready) ok = 1'b1;
      @(posedge PCLK);
      #1;
    end
    tx_valid = 1'b0;
    if (!ok) check("tx_push_timeout", 0, 1);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol  = pol;
    cpha  = pha;
    lsbfe = lsb;
    sclk  = pol;
    tick(HP);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    tick(HP);
    check("oe_active", miso_oe, 1);
  endtask

  task automatic frame_end();
    tick(HP);
    ss_n = 1'b1;
    tick(2 * HP);
    check("oe_idle", miso_oe, 0);
  endtask

  // Master side of one word; optionally offers a tx word to the slave at bit push_at.
  task automatic xfer_word(input logic [7:0] mo, input int nbits, input int push_at,
                           input logic [7:0] push_val, output logic [7:0] got);
    int b;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = lsbfe ? i : 7 - i;
      if (i == push_at) tx_push(push_val);
      if (!cpha) begin
        mosi = mo[b];
        tick(HP);
        got[b] = miso;
        sclk = ~cpol;
        tick(HP);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[b];
        tick(HP);
        got[b] = miso;
        sclk = cpol;
        tick(HP);
      end
    end
    if (nbits == 8) begin
      if (miso_q.size() == 0) check("miso_q_empty", 1, 0);
      else check("miso", got, miso_q.pop_front());
    end
  endtask

  task automatic one_word(input logic [7:0] tx, input logic [7:0] mo);
    tx_push(tx);
    miso_q.push_back(tx);
    rx_q.push_back(mo);
    frame_begin();
    xfer_word(mo, 8, -1, 8'h00, mi);
    frame_end();
    check("tx_ready_after", tx_ready, 1);
  endtask

  initial begin
    PRESET = 1'b1; spi_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    rx_ready = 1'b1; err_clr = 1'b0;
    tick(3);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    PRESET = 1'b0;
    tick(HP);

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    one_word(8'hA5, 8'h3C);

    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b0);
      one_word(8'h7E, 8'h81);
    end

    set_mode(1'b0, 1'b0, 1'b1);
    one_word(8'h80, 8'h01);

    // Overrun: two words, consumer stalled
    set_mode(1'b0, 1'b0, 1'b0);
    clear_err();
    rx_ready = 1'b0;
    rx_q.push_back(8'h11);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hFF);
    frame_begin();
    xfer_word(8'h11, 8, -1, 8'h00, mi);
    xfer_word(8'h22, 8, -1, 8'h00, mi);
    frame_end();
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    check("ovr_underrun", underrun, 1);
    clear_err();
    check("ovr_cleared", overrun, 0);
    check("und_cleared", underrun, 0);
    rx_ready = 1'b1;
    tick(4);
    check("ovr_drained", rx_valid, 0);

    // Underrun, then a word offered mid-word feeds the next word
    rx_q.push_back(8'h5A);
    rx_q.push_back(8'hA6);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hC3);
    frame_begin();
    xfer_word(8'h5A, 8, 3, 8'hC3, mi);
    xfer_word(8'hA6, 8, -1, 8'h00, mi);
    frame_end();
    check("und_flag", underrun, 1);
    clear_err();

    // Partial frame is discarded, next frame restarts bit count
    tx_push(8'h96);
    frame_begin();
    xfer_word(8'hFF, 5, -1, 8'h00, mi);
    frame_end();
    check("abort_rx_valid", rx_valid, 0);
    one_word(8'h69, 8'h3C);

    // Reset mid-word
    tx_push(8'h55);
    frame_begin();
    xfer_word(8'hF0, 4, -1, 8'h00, mi);
    PRESET = 1'b1;
    ss_n   = 1'b1;
    tick(1);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_underrun", underrun, 0);
    PRESET = 1'b0;
    tick(2 * HP);
    one_word(8'h5A, 8'hA5);

    tick(HP);
    check("rx_q_drained", rx_q.size(), 0);
    check("miso_q_drained", miso_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
